bcd_7seg_scan: RTL and testbench
================================

BCD_7SEG_SCAN -- requirements
Module: bcd_7seg_scan

Interface
REQ-001 Parameters SHALL be: numberOfDigits, default 3, BCD digit count; busWidth, default 4, bits per digit; refreshDiv, default 50000, clock cycles per digit slot (minimum 2).
REQ-002 Ports SHALL be:
- clk  in  1  rising-edge clock
- rst  in  1  reset
- digitIn  in  busWidth*numberOfDigits  BCD word from number_2_10; digit 0 = bits [busWidth-1:0] = least significant
- digitCIn  in  1  overflow carry from number_2_10, sampled with digitIn
- digitValid  in  1  digitIn/digitCIn valid
- digitReady  out  1  block can accept a word
- segOut  out  7  active-high segments {g,f,e,d,c,b,a}
- anodeOut  out  numberOfDigits  active-high one-hot digit select
- ovfOut  out  1  displayed word carried overflow
REQ-003 One clock, clk; reset is synchronous and active-high, named rst.

Function
REQ-004 A word SHALL be accepted on a rising edge where digitValid=1 and digitReady=1, and stored in a single-entry pending register.
REQ-005 digitReady SHALL be 1 when the pending register is empty and 0 when it is full; it SHALL NOT depend combinationally on digitValid.
REQ-006 The state machine SHALL have two states:
- IDLE: no word displayed yet.
- SCAN: a word is being displayed.
REQ-007 In IDLE with pending full, the pending word SHALL move to the display register on the next edge, and the state SHALL go to SCAN with slot index 0 and prescaler 0.
REQ-008 In SCAN, a prescaler SHALL count 0..refreshDiv-1.
- At refreshDiv-1 it SHALL wrap to 0 and advance the slot index.
- The slot index SHALL count 0..numberOfDigits-1 and wrap to 0.
REQ-009 The pending word SHALL transfer to the display register only on the edge where the slot index wraps from numberOfDigits-1 to 0 (frame boundary), so no frame shows mixed words.
REQ-010 The pending register SHALL empty on the transfer edge and digitReady SHALL be 1 from the following cycle; a word offered in that following cycle SHALL be accepted.
REQ-011 Segment encoding per digit value:
- 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110
- 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111
- any value above 9 = 1000000 (dash)
REQ-012 In SCAN, anodeOut SHALL be one-hot at the slot index, and segOut SHALL be the encoding of that display digit.
- Both outputs SHALL be registered and update one cycle after a slot change.
REQ-013 In SCAN, if the displayed digitCIn=1, ovfOut SHALL be 1 and every digit SHALL show the dash; otherwise ovfOut SHALL be 0.
REQ-014 In IDLE, anodeOut, segOut and ovfOut SHALL be all zeros.
REQ-015 When busWidth>4, only the low 4 bits of each digit SHALL be decoded, with the upper bits ignored.

Reset
REQ-016 With rst=1 at an edge, on that edge:
- state SHALL go to IDLE.
- pending register SHALL empty and any held word SHALL be dropped.
- display register, prescaler and slot index SHALL clear to 0.
- outputs SHALL reset to segOut=0, anodeOut=0, ovfOut=0, digitReady=1.
REQ-017 A reset in mid-frame SHALL abandon the frame with no partial-frame completion; digitValid SHALL be ignored while rst=1.

Configuration
REQ-018 Macro LEADING_ZERO_BLANK_EN:
- Defined: each display digit above the most significant nonzero digit that has value 0 SHALL drive segOut=0000000 while its anode still scans. Digit 0 SHALL never blank. With overflow, the dash display SHALL override blanking.
- Undefined: all digits SHALL display, including leading zeros.

Verification
REQ-019 Benches SHALL use numberOfDigits=3, busWidth=4, refreshDiv=4 and cover the directed scenarios below:
- Reset, then idle 20 cycles -> digitReady=1, segOut=0, anodeOut=000, ovfOut=0 throughout.
- Offer {5,5,5}, digitCIn=0, one cycle -> accepted; SCAN entered; anodeOut cycles 001,010,100, each held 4 cycles; segOut=1101101 in every slot.
- Offer {0,0,3} -> slots show 1001111, then 0000000, 0000000 with LEADING_ZERO_BLANK_EN defined, or 0111111, 0111111 without it.
- While {1,2,3} is displayed, offer {9,9,9} in slot 0 -> digitReady drops to 0, {1,2,3} completes its frame, {9,9,9} (1101111) appears in slot 0 of the next frame, and digitReady returns to 1 one cycle after the transfer.
- Offer {1,2,3} with digitCIn=1 -> ovfOut=1 and all slots show 1000000; a following word {0,0,7} with digitCIn=0 clears ovfOut at the next frame boundary.
- Assert rst in slot 1 with a pending word -> the next cycle shows IDLE outputs with digitReady=1, and the dropped word never appears.

Source files
------------

// File: rtl/bcd_7seg_scan.sv
// bcd_7seg_scan: multiplexed 7-segment driver for a BCD word.
// Holds one pending word and one displayed word. The display is scanned one
// digit per refreshDiv clocks. A pending word is swapped in only at a frame
// boundary, so a frame never shows two different words.
// Optional feature macro: LEADING_ZERO_BLANK_EN blanks leading zero digits.
// Ports:
//   clk, rst    - clock and synchronous active-high reset
//   digitIn     - BCD word, digit 0 in the least significant busWidth bits
//   digitCIn    - overflow carry that travels with digitIn
//   digitValid  - digitIn/digitCIn valid
//   digitReady  - pending slot is empty
//   segOut      - active-high segments {g,f,e,d,c,b,a}
//   anodeOut    - active-high one-hot digit select
//   ovfOut      - the displayed word carried overflow
module bcd_7seg_scan #(
  parameter int unsigned numberOfDigits = 3,
  parameter int unsigned busWidth       = 4,
  parameter int unsigned refreshDiv     = 50000
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [busWidth*numberOfDigits-1:0] digitIn,
  input  logic                               digitCIn,
  input  logic                               digitValid,
  output logic                               digitReady,
  output logic [6:0]                         segOut,
  output logic [numberOfDigits-1:0]          anodeOut,
  output logic                               ovfOut
);

  localparam int unsigned wordW = busWidth * numberOfDigits;
  localparam int unsigned slotW = (numberOfDigits > 1) ? $clog2(numberOfDigits) : 1;
  localparam int unsigned presW = $clog2(refreshDiv);
  localparam logic [presW-1:0] presLast = presW'(refreshDiv - 1);
  localparam logic [slotW-1:0] slotLast = slotW'(numberOfDigits - 1);
  localparam logic [6:0] segDash = 7'b1000000;

  typedef enum logic {IDLE, SCAN} stateT;

  stateT                state, stateNext;
  logic                 pendFull, pendFullNext;
  logic [wordW-1:0]     pendWord, pendWordNext;
  logic                 pendCarry, pendCarryNext;
  logic [wordW-1:0]     dispWord, dispWordNext;
  logic                 dispCarry, dispCarryNext;
  logic [presW-1:0]     presc, prescNext;
  logic [slotW-1:0]     slotIdx, slotNext;
  logic [6:0]           segNext;
  logic [numberOfDigits-1:0] anodeNext;
  logic                 ovfNext;
  logic                 readyNext;

  logic [3:0]           nib [numberOfDigits];
  logic [3:0]           curNib;
  logic                 blankSlot;

  // Digit value to active-high segments; anything above 9 shows a dash.
  function automatic logic [6:0] segEncode(input logic [3:0] v);
    case (v)
      4'd0:    segEncode = 7'b0111111;
      4'd1:    segEncode = 7'b0000110;
      4'd2:    segEncode = 7'b1011011;
      4'd3:    segEncode = 7'b1001111;
      4'd4:    segEncode = 7'b1100110;
      4'd5:    segEncode = 7'b1101101;
      4'd6:    segEncode = 7'b1111101;
      4'd7:    segEncode = 7'b0000111;
      4'd8:    segEncode = 7'b1111111;
      4'd9:    segEncode = 7'b1101111;
      default: segEncode = segDash;
    endcase
  endfunction

  // Low nibble of each displayed digit and the one at the current slot.
  always_comb begin
    curNib = 4'd0;
    for (int i = 0; i < int'(numberOfDigits); i++) begin
      nib[i] = 4'(dispWord[i*busWidth +: busWidth]);
      if (slotIdx == slotW'(i)) curNib = nib[i];
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  // Walk down from the top digit; a slot blanks while every digit from the
  // top down to it is zero. Digit 0 is never considered.
  always_comb begin
    logic upperZero;
    upperZero = 1'b1;
    blankSlot = 1'b0;
    for (int i = int'(numberOfDigits) - 1; i > 0; i--) begin
      if (nib[i] != 4'd0) upperZero = 1'b0;
      if (slotIdx == slotW'(i) && upperZero) blankSlot = 1'b1;
    end
  end
`else
  always_comb blankSlot = 1'b0;
`endif

  // Next-state, handshake and output decode.
  always_comb begin
    stateNext     = state;
    pendFullNext  = pendFull;
    pendWordNext  = pendWord;
    pendCarryNext = pendCarry;
    dispWordNext  = dispWord;
    dispCarryNext = dispCarry;
    prescNext     = presc;
    slotNext      = slotIdx;
    segNext       = 7'b0;
    anodeNext     = '0;
    ovfNext       = 1'b0;

    // Accept only when empty; a full register cannot be refilled this edge,
    // so accept and transfer never collide.
    if (digitValid && digitReady) begin
      pendFullNext  = 1'b1;
      pendWordNext  = digitIn;
      pendCarryNext = digitCIn;
    end

    case (state)
      IDLE: begin
        if (pendFull) begin
          dispWordNext  = pendWord;
          dispCarryNext = pendCarry;
          pendFullNext  = 1'b0;
          stateNext     = SCAN;
          prescNext     = '0;
          slotNext      = '0;
        end
      end
      SCAN: begin
        for (int i = 0; i < int'(numberOfDigits); i++)
          anodeNext[i] = (slotIdx == slotW'(i));
        ovfNext = dispCarry;
        if (dispCarry)      segNext = segDash;
        else if (blankSlot) segNext = 7'b0;
        else                segNext = segEncode(curNib);

        if (presc == presLast) begin
          prescNext = '0;
          if (slotIdx == slotLast) begin
            slotNext = '0;
            // Frame boundary: the only place a new word may be shown.
            if (pendFull) begin
              dispWordNext  = pendWord;
              dispCarryNext = pendCarry;
              pendFullNext  = 1'b0;
            end
          end else begin
            slotNext = slotIdx + slotW'(1);
          end
        end else begin
          prescNext = presc + presW'(1);
        end
      end
      default: stateNext = IDLE;
    endcase

    readyNext = ~pendFullNext;
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pendFull   <= 1'b0;
      pendWord   <= '0;
      pendCarry  <= 1'b0;
      dispWord   <= '0;
      dispCarry  <= 1'b0;
      presc      <= '0;
      slotIdx    <= '0;
      segOut     <= 7'b0;
      anodeOut   <= '0;
      ovfOut     <= 1'b0;
      digitReady <= 1'b1;
    end else begin
      state      <= stateNext;
      pendFull   <= pendFullNext;
      pendWord   <= pendWordNext;
      pendCarry  <= pendCarryNext;
      dispWord   <= dispWordNext;
      dispCarry  <= dispCarryNext;
      presc      <= prescNext;
      slotIdx    <= slotNext;
      segOut     <= segNext;
      anodeOut   <= anodeNext;
      ovfOut     <= ovfNext;
      digitReady <= readyNext;
    end
  end

endmodule

// File: tb/tb_bcd_7seg_scan.sv
// Testbench for bcd_7seg_scan (3 digits, 4-bit digits, 4 clocks per slot).
// A reference model tracks the pending/displayed words and the time spent
// scanning; slot and frame position are derived arithmetically from that time.
// Honors LEADING_ZERO_BLANK_EN the same way the design does.
module tb_bcd_7seg_scan;
  localparam int N = 3;
  localparam int BW = 4;
  localparam int R = 4;
  localparam int FRAME = N * R;

  logic          clk = 1'b0;
  logic          rst;
  logic [N*BW-1:0] digitIn;
  logic          digitCIn;
  logic          digitValid;
  logic          digitReady;
  logic [6:0]    segOut;
  logic [N-1:0]  anodeOut;
  logic          ovfOut;

  always #5 clk = ~clk;

  bcd_7seg_scan #(.numberOfDigits(N), .busWidth(BW), .refreshDiv(R)) dut (
    .clk(clk), .rst(rst), .digitIn(digitIn), .digitCIn(digitCIn),
    .digitValid(digitValid), .digitReady(digitReady), .segOut(segOut),
    .anodeOut(anodeOut), .ovfOut(ovfOut)
  );

  int checks = 0;
  int failures = 0;

  // Reference model state.
  bit mScan = 0;
  bit mPendFull = 0;
  bit mPendC = 0;
  bit mDispC = 0;
  int mT = 0;
  int mDisp [N];
  int mPend [N];

  logic [6:0] segTab [10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                              7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                              7'b1111111, 7'b1101111};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] expSegFor(input int slot);
    if (mDispC) return 7'b1000000;
`ifdef LEADING_ZERO_BLANK_EN
    begin
      int msnz;
      msnz = 0;
      for (int i = 0; i < N; i++) if (mDisp[i] != 0) msnz = i;
      if (slot > msnz) return 7'b0;
    end
`endif
    if (mDisp[slot] > 9) return 7'b1000000;
    return segTab[mDisp[slot]];
  endfunction

  // One clock: predict registered outputs from the pre-edge model, advance
  // the model with the sampled inputs, then compare just after the edge.
  task automatic tick();
    logic [6:0]   eSeg;
    logic [N-1:0] eAn;
    logic         eOvf;
    bit           acc, r;
    logic [N*BW-1:0] w;
    logic         c;
    int           slot;
    r = rst; w = digitIn; c = digitCIn;
    acc = !r && digitValid && !mPendFull;
    eSeg = '0; eAn = '0; eOvf = 1'b0;
    if (!r && mScan) begin
      slot = mT / R;
      eAn  = N'(1 << slot);
      eOvf = mDispC;
      eSeg = expSegFor(slot);
    end
    @(posedge clk);
    if (r) begin
      mScan = 0; mPendFull = 0; mT = 0; mDispC = 0;
      for (int i = 0; i < N; i++) mDisp[i] = 0;
    end else begin
      if (!mScan) begin
        if (mPendFull) begin
          mDisp = mPend; mDispC = mPendC; mPendFull = 0; mScan = 1; mT = 0;
        end
      end else if (mT == FRAME - 1) begin
        mT = 0;
        if (mPendFull) begin
          mDisp = mPend; mDispC = mPendC; mPendFull = 0;
        end
      end else begin
        mT++;
      end
      if (acc) begin
        mPendFull = 1; mPendC = c;
        for (int i = 0; i < N; i++) mPend[i] = int'((w >> (BW * i)) & 4'hF);
      end
    end
    #1;
    chk("anode", 32'(anodeOut), 32'(eAn));
    chk("seg", 32'(segOut), 32'(eSeg));
    chk("ovf", 32'(ovfOut), 32'(eOvf));
    chk("ready", 32'(digitReady), 32'(!mPendFull));
  endtask

  task automatic offer(input logic [N*BW-1:0] w, input logic c);
    bit done;
    done = 0;
    digitIn = w; digitCIn = c; digitValid = 1'b1;
    for (int k = 0; k < 4 * FRAME && !done; k++) begin
      done = !mPendFull;
      tick();
    end
    digitValid = 1'b0;
  endtask

  task automatic runFor(input int n);
    repeat (n) tick();
  endtask

  initial begin
    rst = 1'b1; digitIn = '0; digitCIn = 1'b0; digitValid = 1'b0;
    tick(); tick();
    rst = 1'b0;

    // Idle after reset: everything dark, ready high.
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("idle_ready", 32'(digitReady), 32'd1);
      chk("idle_anode", 32'(anodeOut), 32'd0);
    end

    // {5,5,5}: accept, enter SCAN, each slot held R cycles.
    offer(12'h555, 1'b0);
    tick();
    for (int s = 0; s < N; s++) begin
      repeat (R) begin
        tick();
        chk("dir555_seg", 32'(segOut), 32'(7'b1101101));
        chk("dir555_anode", 32'(anodeOut), 32'(1 << s));
      end
    end

    // {0,0,3}: leading zeros blank or show depending on the build.
    offer(12'h003, 1'b0);
    runFor(2 * FRAME);

    // {1,2,3} displayed, {9,9,9} offered in slot 0 of its first frame.
    rst = 1'b1; tick(); rst = 1'b0;
    offer(12'h123, 1'b0);
    tick();
    offer(12'h999, 1'b0);
    chk("dir999_ready_low", 32'(digitReady), 32'd0);
    runFor(2 * FRAME);

    // Overflow word, then a clean word clears ovfOut at the next boundary.
    offer(12'h123, 1'b1);
    offer(12'h007, 1'b0);
    runFor(3 * FRAME);

    // Reset in slot 1 with a word pending; the word must never appear.
    offer(12'h888, 1'b0);
    for (int k = 0; k < 2 * FRAME; k++) begin
      if (mScan && (mT / R) == 1 && mPendFull) break;
      tick();
    end
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst_ready", 32'(digitReady), 32'd1);
    chk("rst_seg", 32'(segOut), 32'd0);
    chk("rst_anode", 32'(anodeOut), 32'd0);
    runFor(2 * FRAME);

    // Randomized traffic including dash digits, carries and stray resets.
    for (int k = 0; k < 600; k++) begin
      logic [N*BW-1:0] w;
      for (int i = 0; i < N; i++)
        w[BW*i +: BW] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      digitIn    = w;
      digitCIn   = ($urandom_range(0, 7) == 0);
      digitValid = ($urandom_range(0, 3) == 0);
      rst        = ($urandom_range(0, 99) == 0);
      tick();
    end
    rst = 1'b0; digitValid = 1'b0;
    runFor(FRAME);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
